// File: rtl/om_sched_if.sv
// Signal group joining a bundle producer, the om_sched sequencer, the OM_top
// multiplier and the result consumer.
interface om_sched_if #(
   parameter int Stage = 8
);
   localparam int WL  = 2 * Stage;
   localparam int XYW = Stage * (Stage - 1) + 1;
   localparam int YXW = Stage * (Stage - 1);

   logic           in_valid;
   logic           in_ready;
   logic [WL-1:0]  in_x;
   logic [WL-1:0]  in_y;
   logic [XYW-1:0] in_xY;
   logic [YXW-1:0] in_yX;

   logic [WL-1:0]  om_x;
   logic [WL-3:0]  om_y;
   logic [XYW-1:0] om_xY;
   logic [YXW-1:0] om_yX;
   logic           om_nReset;
   logic [WL-1:0]  om_z;

   logic           res_valid;
   logic           res_ready;
   logic [WL-1:0]  res_z;

   logic           busy;
   logic [15:0]    done_cnt;

   modport slave (
      input  in_valid, in_x, in_y, in_xY, in_yX, om_z, res_ready,
      output in_ready, om_x, om_y, om_xY, om_yX, om_nReset,
             res_valid, res_z, busy, done_cnt
   );

   modport master (
      output in_valid, in_x, in_y, in_xY, in_yX, om_z, res_ready,
      input  in_ready, om_x, om_y, om_xY, om_yX, om_nReset,
             res_valid, res_z, busy, done_cnt
   );
endinterface

// File: rtl/om_sched.sv
// Operation sequencer for OM_top: holds each accepted operand bundle for CalcCycles,
// captures z into a one-entry result slot, then clears the multiplier for ClrCycles.
module om_sched #(
   parameter int Stage      = 8,
   parameter int CalcCycles = 2,
   parameter int ClrCycles  = 1
) (
   input logic       clk,
   input logic       Reset,
   om_sched_if.slave bus
);
   localparam int WL  = 2 * Stage;
   localparam int XYW = Stage * (Stage - 1) + 1;
   localparam int YXW = Stage * (Stage - 1);
   localparam logic [7:0] CALC_INIT = 8'(CalcCycles);
   localparam logic [7:0] CLR_INIT  = 8'(ClrCycles);

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      IDLE  = 2'd1,
      CALC  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [7:0] cnt_r;
   logic [7:0] cnt_nxt_s;
   logic       load_s;
   logic       cap_s;
   logic       slot_free_s;
   logic       unused_s;

   // The two low multiplier digits are not used by OM_top.
   assign unused_s    = ^bus.in_y[1:0];
   assign slot_free_s = !bus.res_valid || bus.res_ready;
   assign bus.in_ready = (state_r == IDLE);
   assign bus.busy     = (state_r != IDLE);

   // Next-state, shared cycle counter, operand load and result capture decisions.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      load_s      = 1'b0;
      cap_s       = 1'b0;
      case (state_r)
         CLEAR: begin
            if (cnt_r == 8'd1) begin
               state_nxt_s = IDLE;
            end else begin
               cnt_nxt_s = cnt_r - 8'd1;
            end
         end
         IDLE: begin
            if (bus.in_valid) begin
               load_s      = 1'b1;
               cnt_nxt_s   = CALC_INIT;
               state_nxt_s = CALC;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == 8'd1) begin
               if (slot_free_s) begin
                  cap_s       = 1'b1;
                  cnt_nxt_s   = CLR_INIT;
                  state_nxt_s = CLEAR;
               end else begin
                  state_nxt_s = HOLD;
               end
            end else begin
               cnt_nxt_s = cnt_r - 8'd1;
            end
         end
         HOLD: begin
            // Operands stay put so the multiplier keeps z stable until the slot frees.
            if (slot_free_s) begin
               cap_s       = 1'b1;
               cnt_nxt_s   = CLR_INIT;
               state_nxt_s = CLEAR;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         default: begin
            cnt_nxt_s   = CLR_INIT;
            state_nxt_s = CLEAR;
         end
      endcase
   end

   // State, counter, multiplier drive, result slot and completion counter registers.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_r       <= CLEAR;
         cnt_r         <= CLR_INIT;
         bus.om_nReset <= 1'b0;
         bus.om_x      <= {WL{1'b0}};
         bus.om_y      <= {(WL-2){1'b0}};
         bus.om_xY     <= {XYW{1'b0}};
         bus.om_yX     <= {YXW{1'b0}};
         bus.res_valid <= 1'b0;
         bus.res_z     <= {WL{1'b0}};
         bus.done_cnt  <= 16'd0;
      end else begin
         state_r       <= state_nxt_s;
         cnt_r         <= cnt_nxt_s;
         bus.om_nReset <= (state_nxt_s != CLEAR);
         if (load_s) begin
            bus.om_x  <= bus.in_x;
            bus.om_y  <= bus.in_y[WL-1:2];
            bus.om_xY <= bus.in_xY;
            bus.om_yX <= bus.in_yX;
         end
         // A capture on the same edge as a drain keeps the slot full with the new product.
         if (cap_s) begin
            bus.res_z     <= bus.om_z;
            bus.res_valid <= 1'b1;
            bus.done_cnt  <= bus.done_cnt + 16'd1;
         end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/om_sched.md
# om_sched

Operation sequencer for the online multiplier `OM_top` (digit-serial, MSD-first, `WL = 2*Stage` redundant operands).
- Accepts operand bundles `x`, `y`, `xY`, `yX` over a valid/ready handshake.
- Holds each bundle stable on the multiplier for a programmed number of cycles, then samples `z` into a one-entry result register.
- Pulses the multiplier's active-low `nReset` between operations.
- Replaces the hand-timed stimulus loop used around `OM_top`, so a stream producer can drive the multiplier back-to-back.

## Interface
Parameters:
- `Stage`, 8: multiplier stage count. `WL = 2*Stage` (localparam).
- `CalcCycles`, 2: cycles each operand bundle is held on the multiplier before `z` is sampled. Legal range 1..255.
- `ClrCycles`, 1: cycles `om_nReset` is held low after each operation. Legal range 1..255.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: operand bundle valid.
- `in_ready`, out, 1: sequencer can accept a bundle.
- `in_x`, in, WL: multiplicand digits.
- `in_y`, in, WL: multiplier digits. Bits [1:0] are ignored.
- `in_xY`, in, Stage*(Stage-1)+1: per-stage x·Y partial-product table.
- `in_yX`, in, Stage*(Stage-1): per-stage y·X partial-product table.
- `om_x`, out, WL: registered to `OM_top.x`.
- `om_y`, out, WL-2: registered to `OM_top.y` (`in_y[WL-1:2]`).
- `om_xY`, out, Stage*(Stage-1)+1: registered to `OM_top.xY`.
- `om_yX`, out, Stage*(Stage-1): registered to `OM_top.yX`.
- `om_nReset`, out, 1: registered, active-low clear to `OM_top.nReset`.
- `om_z`, in, WL: `OM_top.z`.
- `res_valid`, out, 1: result register full.
- `res_ready`, in, 1: consumer takes the result.
- `res_z`, out, WL: captured product.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `done_cnt`, out, 16: count of results written to the result register; wraps at 16'hFFFF→0.

## Operation
- FSM states: CLEAR, IDLE, CALC, HOLD.
- **Reset** (`Reset`=1 at an edge):
  - state←CLEAR, clear counter←ClrCycles.
  - `om_nReset`←0; `om_x`/`om_y`/`om_xY`/`om_yX`←0.
  - `res_valid`←0, `res_z`←0, `done_cnt`←0.
  - Reset mid-operation abandons the operation: no result is produced and an unconsumed result is discarded.
- **CLEAR**:
  - `om_nReset`=0 for exactly ClrCycles cycles, then →IDLE with `om_nReset`←1.
  - Operand registers keep their values.
- **IDLE**:
  - `in_ready`=1, `om_nReset`=1.
  - On `in_valid`&&`in_ready`: operand registers ← inputs (`om_y`←`in_y[WL-1:2]`), calc counter←CalcCycles, →CALC.
- **CALC**:
  - Operands stay stable, `in_ready`=0.
  - The counter decrements each cycle.
  - On the final CALC cycle, the edge ending it does one of the following:
    - If the result slot is free (`!res_valid || res_ready`): `res_z`←`om_z`, `res_valid`←1, `done_cnt`++, →CLEAR.
    - Otherwise →HOLD.
- **HOLD**:
  - Operands and `om_nReset`=1 are held, so the multiplier keeps driving a stable `z`.
  - On the first edge where the slot is free: capture as above, →CLEAR.
- **Result handshake**:
  - `res_valid` clears on `res_valid`&&`res_ready` unless a capture happens on the same edge.
  - A simultaneous drain and capture leaves `res_valid`=1 with the new `res_z`.
  - `res_z` is stable while `res_valid`&&!`res_ready`.
- `in_valid` is ignored outside IDLE. Bundle data need only be valid in the cycle it is accepted.
- `busy` is combinational from the state.

## Timing
- All outputs are registered except `in_ready` (state==IDLE) and `busy`.
- After `Reset` falls: ClrCycles cycles of `om_nReset`=0, then `in_ready`=1 in the next cycle.
- Accept at edge E: `om_*` show the new operands in cycle E+1.
  - `z` is sampled at edge E+CalcCycles.
  - `res_valid`=1 from cycle E+CalcCycles.
- Minimum period between accepts with no result backpressure is 1+CalcCycles+ClrCycles cycles (4 with defaults).
- HOLD adds exactly the number of stalled cycles; nothing else changes.

## Test plan
Bench stub for all scenarios: `om_z` = `om_x`+1 when `om_nReset`=1, else 0 (combinational). Defaults Stage=8, CalcCycles=2, ClrCycles=1 unless stated.

1. **Reset**: assert `Reset` for 3 cycles, then release.
   - During and after reset: `om_nReset`=0, `res_valid`=0, `done_cnt`=0.
   - `in_ready` rises exactly 1 cycle after release.
2. **Single operation**: `in_x`=16'h1234, `in_y`=16'h29E0, `res_ready`=1.
   - `om_y`=14'h0A78.
   - `res_z`=16'h1235 with `res_valid` rising 2 cycles after accept.
   - `om_nReset` low for 1 cycle after the capture; `done_cnt`=1.
3. **Stream**: 100 random bundles, `in_valid` held high, `res_ready`=1.
   - Every result equals `in_x`+1, in order.
   - Accepts spaced exactly 4 cycles apart; final `done_cnt`=100.
4. **Backpressure**: `res_ready`=0 for 10 cycles while a second op finishes CALC.
   - State HOLD; operands and `res_z` stable.
   - On `res_ready`=1, drain and capture happen on the same edge; no result is lost or duplicated.
5. **Mid-operation reset**: pulse `Reset` for 1 cycle during CALC.
   - `res_valid` stays 0, `done_cnt`=0.
   - `om_nReset`=0 for ClrCycles cycles, then a normal op completes correctly.
6. **Parameter sweep**: CalcCycles=5, ClrCycles=3.
   - Accept spacing is 9 cycles; `done_cnt` wraps 16'hFFFF→0 when forced near the limit.
